// File: rtl/bram_wb_snap.sv
// bram_wb_snap: single-clock snapshot buffer. Fabric samples are streamed into
// an internal BRAM under an arm/trigger state machine, and a wishbone slave
// reads the captured data, writes memory with byte lanes and reaches the
// control/status registers. Every transfer is acked ACK_WAIT+1 cycles after it
// is accepted.
//
// Optional feature macro: BRAM_WB_SNAP_RING_EN
//   Adds ring capture (CTRL bit2), forced stop (CTRL bit3) and the WPTR register.
//
// Ports:
//   wbs_clk_i       sole clock, rising edge
//   wbs_rst_n_i     asynchronous active-low reset
//   wbs_cyc_i/stb_i wishbone cycle / strobe
//   wbs_we_i        write enable
//   wbs_sel_i       byte-lane selects
//   wbs_adr_i       word address, MSB=1 selects register space
//   wbs_dat_i       write data
//   wbs_dat_o       read data, valid from the ack cycle until the next ack
//   wbs_ack_o       one-cycle transfer acknowledge
//   fabric_data_in  sample
//   fabric_valid    sample qualifier
//   fabric_trig     trigger, qualified by fabric_valid
//   snap_busy       state is WAIT_TRIG or CAPTURE
//   snap_done       state is DONE
//
// Register map (register space, low 2 address bits decoded):
//   0 CTRL   bit0 ARM (write-1, reads 0), bit1 TRIG_MODE, bit2 RING, bit3 STOP
//   1 STATUS bit0 busy, bit1 done
//   2 COUNT  words captured
//   3 WPTR   next write address (ring build only, otherwise 0)
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | out of reset, nothing armed
// WAIT_TRIG | armed, waiting for a valid sample with trigger
// CAPTURE   | every valid sample is written and counted
// DONE      | buffer full (or stopped), fabric ignored

module bram_wb_snap #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ACK_WAIT   = 2
) (
  input  logic                    wbs_clk_i,
  input  logic                    wbs_rst_n_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [ADDR_WIDTH:0]     wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_ack_o,
  input  logic [DATA_WIDTH-1:0]   fabric_data_in,
  input  logic                    fabric_valid,
  input  logic                    fabric_trig,
  output logic                    snap_busy,
  output logic                    snap_done
);

  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] WPTR_ONE   = ADDR_WIDTH'(1);
  localparam logic [3:0]            WAIT_LOAD  = (ACK_WAIT == 0) ? 4'd0 : 4'(ACK_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_CAPTURE   = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Wishbone transaction tracking
  logic                  pending;
  logic [3:0]            wait_cnt;
  logic                  lat_we;
  logic [ADDR_WIDTH:0]   lat_adr;
  logic [NUM_LANES-1:0]  lat_sel;
  logic [DATA_WIDTH-1:0] lat_dat;

  logic                  req;
  logic                  accept;
  logic                  fire;
  logic                  txn_we;
  logic [ADDR_WIDTH:0]   txn_adr;
  logic [NUM_LANES-1:0]  txn_sel;
  logic [DATA_WIDTH-1:0] txn_dat;

  // Register file / FSM
  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   count, count_nxt;
  logic [ADDR_WIDTH-1:0] wptr, wptr_nxt;
  logic                  trig_mode;
  logic                  ring_mode;
  logic                  ctrl_wr;
  logic                  arm_req;
  logic                  stop_req;
  logic                  mem_wr;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_adr;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic [DATA_WIDTH-1:0] reg_rdata;

  assign req    = wbs_cyc_i & wbs_stb_i;
  // The ack cycle blocks acceptance so back-to-back transfers start one cycle later.
  assign accept = req & ~pending & ~wbs_ack_o;

  // With no wait cycles the transfer completes straight from the live bus;
  // otherwise the wait down-counter must reach terminal count with the bus still held.
  assign fire = (ACK_WAIT == 0) ? accept : (pending & req & (wait_cnt == 4'd0));

  assign txn_we  = pending ? lat_we  : wbs_we_i;
  assign txn_adr = pending ? lat_adr : wbs_adr_i;
  assign txn_sel = pending ? lat_sel : wbs_sel_i;
  assign txn_dat = pending ? lat_dat : wbs_dat_i;

  assign ctrl_wr = fire & txn_we & txn_adr[ADDR_WIDTH] & (txn_adr[1:0] == 2'd0) & txn_sel[0];
  assign arm_req = ctrl_wr & txn_dat[0];
  assign mem_wr  = fire & txn_we & ~txn_adr[ADDR_WIDTH] & (state != S_CAPTURE);

`ifdef BRAM_WB_SNAP_RING_EN
  assign stop_req = ctrl_wr & txn_dat[3];

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      ring_mode <= 1'b0;
    end else if (ctrl_wr) begin
      ring_mode <= txn_dat[2];
    end
  end
`else
  assign stop_req  = 1'b0;
  assign ring_mode = 1'b0;
`endif

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      trig_mode <= 1'b0;
    end else if (ctrl_wr) begin
      trig_mode <= txn_dat[1];
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (txn_adr[1:0])
      2'd0: begin
        reg_rdata[1] = trig_mode;
        reg_rdata[2] = ring_mode;
      end
      2'd1: reg_rdata[1:0] = {snap_done, snap_busy};
      2'd2: reg_rdata[ADDR_WIDTH:0] = count;
      default: begin
`ifdef BRAM_WB_SNAP_RING_EN
        reg_rdata[ADDR_WIDTH-1:0] = wptr;
`endif
      end
    endcase
  end

  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      pending   <= 1'b0;
      wait_cnt  <= 4'd0;
      lat_we    <= 1'b0;
      lat_adr   <= '0;
      lat_sel   <= '0;
      lat_dat   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= fire;
      if (accept && (ACK_WAIT != 0)) begin
        pending  <= 1'b1;
        wait_cnt <= WAIT_LOAD;
        lat_we   <= wbs_we_i;
        lat_adr  <= wbs_adr_i;
        lat_sel  <= wbs_sel_i;
        lat_dat  <= wbs_dat_i;
      end else if (pending) begin
        // Either the master let go (abort) or the wait expired (fire).
        if (!req || (wait_cnt == 4'd0)) begin
          pending <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
        end
      end
      if (fire && !txn_we) begin
        wbs_dat_o <= txn_adr[ADDR_WIDTH] ? reg_rdata : mem[txn_adr[ADDR_WIDTH-1:0]];
      end
    end
  end

  // Capture has priority; a bus write on the same cycle can only collide in
  // WAIT_TRIG, where the trigger sample is the one worth keeping.
  always_ff @(posedge wbs_clk_i) begin
    if (cap_we) begin
      mem[cap_adr] <= fabric_data_in;
    end else if (mem_wr) begin
      for (int b = 0; b < NUM_LANES; b++) begin
        if (txn_sel[b]) begin
          mem[txn_adr[ADDR_WIDTH-1:0]][b*8 +: 8] <= txn_dat[b*8 +: 8];
        end
      end
    end
  end

  // FSM: state register
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
    if (!wbs_rst_n_i) begin
      state     <= S_IDLE;
      count     <= '0;
      wptr      <= '0;
      snap_busy <= 1'b0;
      snap_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      wptr      <= wptr_nxt;
      snap_busy <= busy_nxt;
      snap_done <= done_nxt;
    end
  end

  // FSM: next state. ARM overrides everything, so a sample arriving with the
  // ARM write is dropped.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    wptr_nxt  = wptr;
    if (arm_req) begin
      state_nxt = txn_dat[1] ? S_WAIT_TRIG : S_CAPTURE;
      count_nxt = '0;
      wptr_nxt  = '0;
    end else if (stop_req) begin
      state_nxt = S_DONE;
    end else begin
      case (state)
        S_WAIT_TRIG: begin
          if (fabric_valid && fabric_trig) begin
            state_nxt = S_CAPTURE;
            count_nxt = COUNT_ONE;
            wptr_nxt  = WPTR_ONE;
          end
        end
        S_CAPTURE: begin
          if (fabric_valid) begin
            wptr_nxt = wptr + WPTR_ONE;
            if (ring_mode) begin
              if (count != COUNT_FULL) begin
                count_nxt = count + COUNT_ONE;
              end
            end else begin
              count_nxt = count + COUNT_ONE;
              if (count == COUNT_LAST) begin
                state_nxt = S_DONE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM: outputs. Status flags are derived from the next state so the
  // registered copies line up with the state register.
  always_comb begin
    cap_we  = 1'b0;
    cap_adr = wptr;
    if (!arm_req && !stop_req) begin
      case (state)
        S_WAIT_TRIG: begin
          if (fabric_valid && fabric_trig) begin
            cap_we  = 1'b1;
            cap_adr = '0;
          end
        end
        S_CAPTURE: cap_we = fabric_valid;
        default: ;
      endcase
    end
    busy_nxt = (state_nxt == S_WAIT_TRIG) || (state_nxt == S_CAPTURE);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule

// File: doc/bram_wb_snap.md
Name: bram_wb_snap

Overview:
- Parametrised successor to the wishbone BRAM: a single-clock snapshot buffer.
- The fabric streams samples into an internal BRAM under control of an arm/trigger state machine.
- The wishbone slave reads captured data, writes memory with byte-lane selects, and accesses control/status registers with a configurable ack wait.
- Sits between ADC/DSP fabric and the wishbone bus in test designs.

Parameters:
- DATA_WIDTH, 32: word width; multiple of 8.
- ADDR_WIDTH, 8: memory depth DEPTH = 2^ADDR_WIDTH words.
- ACK_WAIT, 2: extra wishbone wait cycles, 0..15.

Ports:
- wbs_clk_i  in  1  sole clock, rising edge.
- wbs_rst_n_i  in  1  reset, asynchronous assert, active-low.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  DATA_WIDTH/8  byte-lane selects.
- wbs_adr_i  in  ADDR_WIDTH+1  word address; MSB=1 selects register space.
- wbs_dat_i  in  DATA_WIDTH  write data.
- wbs_dat_o  out  DATA_WIDTH  read data.
- wbs_ack_o  out  1  transfer acknowledge.
- fabric_data_in  in  DATA_WIDTH  sample.
- fabric_valid  in  1  sample qualifier.
- fabric_trig  in  1  trigger, qualified by fabric_valid.
- snap_busy  out  1  state is WAIT_TRIG or CAPTURE.
- snap_done  out  1  state is DONE.

Behaviour:
- Clock/reset: one clock, wbs_clk_i; reset wbs_rst_n_i is asynchronous, active-low.
- Reset values: wbs_ack_o=0, wbs_dat_o=0, snap_busy=0, snap_done=0, state IDLE, COUNT=0, CTRL=0. BRAM contents are not reset.
- Wishbone acceptance and ack:
  - A transfer is accepted in cycle 0 when cyc&stb and no transfer is pending.
  - wbs_ack_o pulses high for exactly one cycle at cycle ACK_WAIT+1.
  - wbs_dat_o is valid in the ack cycle and holds until the next ack.
- Wishbone write/abort rules:
  - Writes commit in the ack cycle.
  - If cyc or stb drops before ack, the transfer is aborted: no ack, no write.
  - No new acceptance occurs during the ack cycle; the earliest back-to-back accept is the cycle after ack.
- Memory space (MSB=0): words of wbs_dat_i are written only to lanes with wbs_sel_i set. During CAPTURE, wishbone memory writes are dropped but still acked. Reads are always allowed.
- Register space (MSB=1, low 2 bits decoded, others read 0):
  - 0 CTRL: bit0 ARM is write-1, self-clearing, reads 0; bit1 TRIG_MODE is R/W.
  - 1 STATUS: bit0 busy, bit1 done (read-only).
  - 2 COUNT: words captured, ADDR_WIDTH+1 bits, zero-extended (read-only).
  - Register writes require wbs_sel_i[0].
- State machine IDLE/WAIT_TRIG/CAPTURE/DONE:
  - ARM from any state clears COUNT; next state is CAPTURE if TRIG_MODE=0, else WAIT_TRIG. A valid sample in the ARM commit cycle is not captured.
  - WAIT_TRIG: fabric_valid&fabric_trig writes that sample to address 0, COUNT=1, go to CAPTURE.
  - CAPTURE: each fabric_valid writes to address COUNT[ADDR_WIDTH-1:0] and increments COUNT. After the write at COUNT=DEPTH-1, go to DONE with COUNT=DEPTH.
  - DONE: fabric input is ignored until the next ARM.
- snap_busy and snap_done are registered and track the state in the same cycle.
- Reset during an active capture returns to IDLE immediately; a pending ack is discarded.

Optional Feature:
- BRAM_WB_SNAP_RING_EN defined:
  - CTRL bit2 RING makes CAPTURE wrap the write address modulo DEPTH and never enter DONE.
  - COUNT saturates at DEPTH.
  - CTRL bit3 STOP (write-1, self-clearing) forces DONE.
  - Register 3 WPTR returns the next write address.
- Undefined: bits 2/3 are ignored and read 0; register 3 reads 0.

Test Plan:
- Reset with ACK_WAIT=2: memory write 0xDEADBEEF to addr 0x05 -> ack exactly 3 cycles after accept; reading addr 0x05 returns 0xDEADBEEF.
- Write 0x11223344 with sel=4'b0110 over 0xFFFFFFFF -> readback 0xFF2233FF.
- TRIG_MODE=0, ARM, stream 256 valid samples 0..255 with gaps -> snap_done=1, COUNT=256, addr k reads k, sample 256 is not written.
- TRIG_MODE=1, ARM, samples 0..9 with trig on value 7 -> address 0 holds 7, snap_busy=1 throughout, COUNT increments from 1.
- Drop stb at cycle 1 of a write to addr 0x10 -> no ack, memory unchanged. Reset mid-CAPTURE -> all outputs 0 the same cycle.
- With BRAM_WB_SNAP_RING_EN: RING, 300 samples, then STOP -> WPTR=44, COUNT=256, addr 0 holds sample 256, done=1.
